// File: rtl/mc_core.sv
// Multicycle core: control FSM, 16 x DATA_W register file, ALU and PC behind a req/ack memory port.
// 3 cycles ALU/branch, 4 ST, 5 LD plus memory wait cycles; a request is held unchanged until acked.
module mc_core #(
   parameter int          DATA_W   = 16,
   parameter int          ADDR_W   = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [3:0]        irout,
   output logic [ADDR_W-1:0] pc_out,
   output logic              carry,
   output logic              halted,
   output logic              illegal
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
      OP_XOR  = 4'h4, OP_SHL  = 4'h5, OP_SHR = 4'h6, OP_LI   = 4'h7,
      OP_LD   = 4'h8, OP_ST   = 4'h9, OP_BEQZ = 4'hA, OP_JMP = 4'hB,
      OP_ADDI = 4'hC, OP_NOP  = 4'hD, OP_ILL = 4'hE, OP_HALT = 4'hF
   } op_t;

   state_t            state, state_nxt;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] regs [16];
   logic [DATA_W-1:0] a, b, d, mdr;

   op_t               op;
   logic [3:0]        rd, ra, rb;
   logic [DATA_W-1:0] imm_d;
   logic [ADDR_W-1:0] imm_a;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_we, take_br;

   assign op     = op_t'(ir[15:12]);
   assign rd     = ir[11:8];
   assign ra     = ir[7:4];
   assign rb     = ir[3:0];
   assign imm_d  = {{(DATA_W-8){ir[7]}}, ir[7:0]};
   assign imm_a  = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
   assign irout  = ir[15:12];
   assign pc_out = pc;

   // Carry defaults to its held value so only ADD/SUB/ADDI change it
   always_comb begin
      alu_res = '0;
      alu_c   = carry;
      alu_we  = 1'b1;
      case (op)
         OP_ADD:  {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
         OP_SUB:  {alu_c, alu_res} = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SHL:  alu_res = {a[DATA_W-2:0], 1'b0};
         OP_SHR:  alu_res = {1'b0, a[DATA_W-1:1]};
         OP_LI:   alu_res = imm_d;
         OP_ADDI: {alu_c, alu_res} = {1'b0, d} + {1'b0, imm_d};
         default: alu_we = 1'b0;
      endcase
   end

   assign take_br = (op == OP_JMP) || ((op == OP_BEQZ) && (d == '0));

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      halted    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ack) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            case (op)
               OP_LD, OP_ST: state_nxt = S_MEM;
               OP_HALT:      state_nxt = S_HALT;
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = (op == OP_ST);
            mem_addr  = ADDR_W'(a);
            mem_wdata = d;
            if (mem_ack) state_nxt = (op == OP_LD) ? S_WB : S_FETCH;
         end
         S_WB:    state_nxt = S_FETCH;
         S_HALT:  halted = 1'b1;
         default: state_nxt = S_FETCH;
      endcase
      // Reset abandons any request in flight so the pending edge cannot complete it
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         halted  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         pc      <= ADDR_W'(RESET_PC);
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         d       <= '0;
         mdr     <= '0;
         carry   <= 1'b0;
         illegal <= 1'b0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_FETCH: begin
               if (mem_ack) begin
                  ir <= mem_rdata[15:0];
                  pc <= pc + ADDR_W'(1);
               end
            end
            S_DECODE: begin
               a <= regs[ra];
               b <= regs[rb];
               d <= regs[rd];
            end
            S_EXEC: begin
               if (alu_we) regs[rd] <= alu_res;
               carry <= alu_c;
               if (take_br) pc <= pc + imm_a;
               if (op == OP_ILL) illegal <= 1'b1;
            end
            S_MEM: begin
               if (mem_ack && (op == OP_LD)) mdr <= mem_rdata;
            end
            S_WB:    regs[rd] <= mdr;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: memory model with address-dependent wait states and a write scoreboard.
module tb_mc_core;
   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic [3:0]    irout;
   logic [AW-1:0] pc_out;
   logic          carry, halted, illegal;

   mc_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(32'h10)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .irout(irout), .pc_out(pc_out), .carry(carry), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] addr; int cyc; int c; int il; } ins_t;
   typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;

   logic [15:0] mem [0:65535];
   ins_t        exp_ins[$];
   wr_t         exp_wr[$];
   ins_t        prev;
   logic [15:0] apc;
   int          n_chk = 0, n_err = 0;
   int          cyc = 0, prev_cyc = 0, wr_cnt = 0, waited = 0;
   bit          have_prev = 0, trace_on = 1, busy = 0;
   logic [AW-1:0] cap_addr;
   logic          cap_we;
   logic [DW-1:0] cap_wdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] r3(input int op, input int rd, input int ra, input int rb);
      return 16'((op << 12) | (rd << 8) | (ra << 4) | rb);
   endfunction

   function automatic logic [15:0] ri(input int op, input int rd, input int imm);
      return 16'((op << 12) | (rd << 8) | (imm & 8'hFF));
   endfunction

   // Data window 0x40..0x5F answers after 2 wait cycles; everything else is zero-wait
   function automatic int waits_for(input logic [15:0] a);
      return (a >= 16'h0040 && a < 16'h0060) ? 2 : 0;
   endfunction

   task automatic ins(input logic [15:0] w, input int cy, input int c, input int il);
      mem[apc] = w;
      exp_ins.push_back('{apc, cy, c, il});
      apc = apc + 16'd1;
   endtask

   task automatic rep(input logic [15:0] a, input int cy, input int c, input int il);
      exp_ins.push_back('{a, cy, c, il});
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] dat);
      exp_wr.push_back('{a, dat});
   endtask

   task automatic fetch_seen();
      ins_t r;
      if (!trace_on) return;
      if (have_prev) begin
         check_val($sformatf("cpi_%h", prev.addr), cyc - prev_cyc, prev.cyc);
         check_val($sformatf("carry_%h", prev.addr), {31'b0, carry}, prev.c);
         check_val($sformatf("illegal_%h", prev.addr), {31'b0, illegal}, prev.il);
      end
      check_val("ins_queue", {31'b0, exp_ins.size() > 0}, 1);
      if (exp_ins.size() > 0) begin
         r = exp_ins.pop_front();
         check_val("fetch_pc", {16'b0, mem_addr}, {16'b0, r.addr});
         prev      = r;
         prev_cyc  = cyc;
         have_prev = 1;
      end
   endtask

   always @(negedge clk) begin
      if (!mem_req) begin
         busy    = 0;
         mem_ack = 1'b0;
      end else if (!busy) begin
         busy      = 1;
         waited    = 0;
         cap_addr  = mem_addr;
         cap_we    = mem_we;
         cap_wdata = mem_wdata;
         if (!mem_we && mem_addr == pc_out) fetch_seen();
         mem_ack   = (waits_for(mem_addr) == 0);
         mem_rdata = mem[mem_addr];
      end else begin
         check_val("hold_addr", {16'b0, mem_addr}, {16'b0, cap_addr});
         check_val("hold_we", {31'b0, mem_we}, {31'b0, cap_we});
         if (cap_we) check_val("hold_wdata", {16'b0, mem_wdata}, {16'b0, cap_wdata});
         waited++;
         mem_ack   = (waited >= waits_for(cap_addr));
         mem_rdata = mem[cap_addr];
      end
   end

   always @(posedge clk) begin
      wr_t e;
      cyc++;
      if (mem_req && mem_ack) begin
         busy = 0;
         if (mem_we) begin
            wr_cnt++;
            mem[mem_addr] = mem_wdata;
            check_val("wr_queue", {31'b0, exp_wr.size() > 0}, 1);
            if (exp_wr.size() > 0) begin
               e = exp_wr.pop_front();
               check_val("wr_addr", {16'b0, mem_addr}, {16'b0, e.addr});
               check_val($sformatf("wr_data_%h", e.addr), {16'b0, mem_wdata}, {16'b0, e.data});
            end
         end
      end
   end

   initial begin
      int req_seen, w0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;

      apc = 16'h0010;
      ins(ri(7, 1, 8'hFF), 3, 0, 0);
      ins(ri(7, 2, 8'h01), 3, 0, 0);
      ins(r3(0, 3, 1, 2), 3, 1, 0);
      ins(r3(1, 4, 2, 2), 3, 1, 0);
      ins(r3(1, 5, 2, 1), 3, 0, 0);
      ins(ri(7, 7, 8'h40), 3, 0, 0);
      ins(r3(9, 2, 7, 0), 6, 0, 0);   wr(16'h40, 16'h0001);
      ins(r3(8, 6, 7, 0), 7, 0, 0);
      ins(ri(7, 13, 8'h60), 3, 0, 0);
      ins(r3(9, 6, 13, 0), 4, 0, 0);  wr(16'h60, 16'h0001);
      ins(ri(12, 13, 1), 3, 0, 0);
      ins(r3(9, 5, 13, 0), 4, 0, 0);  wr(16'h61, 16'h0002);
      ins(r3(8, 14, 13, 0), 5, 0, 0);
      ins(r3(5, 10, 1, 0), 3, 0, 0);
      ins(ri(12, 13, 1), 3, 0, 0);
      ins(r3(9, 10, 13, 0), 4, 0, 0); wr(16'h62, 16'hFFFE);
      ins(r3(6, 11, 1, 0), 3, 0, 0);
      ins(ri(12, 13, 1), 3, 0, 0);
      ins(r3(9, 11, 13, 0), 4, 0, 0); wr(16'h63, 16'h7FFF);
      ins(r3(4, 10, 10, 1), 3, 0, 0);
      ins(r3(3, 10, 10, 14), 3, 0, 0);
      ins(r3(2, 10, 10, 5), 3, 0, 0);
      ins(ri(12, 13, 1), 3, 0, 0);
      ins(r3(9, 10, 13, 0), 4, 0, 0); wr(16'h64, 16'h0002);
      ins(r3(0, 12, 1, 1), 3, 1, 0);
      ins(ri(12, 12, 1), 3, 0, 0);
      ins(ri(12, 12, 1), 3, 1, 0);
      ins(ri(10, 12, 8'hFE), 3, 1, 0);
      rep(16'h2A, 3, 0, 0);
      rep(16'h2B, 3, 0, 0);
      ins(ri(12, 13, 1), 3, 0, 0);
      ins(r3(9, 12, 13, 0), 4, 0, 0); wr(16'h65, 16'h0001);
      ins(ri(11, 0, 8'hD0), 3, 0, 0);
      apc = 16'hFFFF;
      ins(ri(11, 0, 8'h03), 3, 0, 0);
      apc = 16'h0003;
      ins(16'hE000, 3, 0, 1);
      ins(ri(12, 13, 1), 3, 0, 1);
      ins(r3(9, 4, 13, 0), 4, 0, 1);  wr(16'h66, 16'h0000);
      ins(16'hF000, 0, 0, 1);

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_req", {31'b0, mem_req}, 0);
      check_val("rst_pc", {16'b0, pc_out}, 32'h10);
      check_val("rst_carry", {31'b0, carry}, 0);
      check_val("rst_halted", {31'b0, halted}, 0);
      check_val("rst_illegal", {31'b0, illegal}, 0);
      rst = 1'b0;
      #1;
      check_val("first_req", {31'b0, mem_req}, 1);
      check_val("first_addr", {16'b0, mem_addr}, 32'h10);

      for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
      check_val("halt_reached", {31'b0, halted}, 1);
      check_val("halt_lat", cyc - prev_cyc, 3);
      trace_on = 0;
      req_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_req) req_seen++;
      end
      check_val("halt_no_req", req_seen, 0);
      check_val("halt_stays", {31'b0, halted}, 1);
      check_val("illegal_sticky", {31'b0, illegal}, 1);
      check_val("halt_irout", {28'b0, irout}, 32'hF);
      check_val("halt_pc", {16'b0, pc_out}, 32'h0007);
      check_val("ins_left", exp_ins.size(), 0);
      check_val("wr_left", exp_wr.size(), 0);

      mem[16'h10] = ri(7, 7, 8'h40);
      mem[16'h11] = r3(9, 7, 7, 0);
      mem[16'h12] = 16'hF000;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      check_val("rst_halt_clear", {31'b0, halted}, 0);
      check_val("rst_illegal_clear", {31'b0, illegal}, 0);
      rst = 1'b0;
      #1;
      check_val("restart_addr", {16'b0, mem_addr}, 32'h10);
      for (int i = 0; i < 30 && !(mem_req && mem_we); i++) @(negedge clk);
      check_val("st_req_seen", {31'b0, mem_req && mem_we}, 1);
      w0 = wr_cnt;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("abandon_wr_cnt", wr_cnt, w0);
      check_val("abandon_mem", {16'b0, mem[16'h40]}, 32'h0001);
      wr(16'h40, 16'h0040);
      rst = 1'b0;
      #1;
      check_val("restart2_req", {31'b0, mem_req}, 1);
      check_val("restart2_pc", {16'b0, pc_out}, 32'h10);
      for (int i = 0; i < 60 && !halted; i++) @(negedge clk);
      check_val("restart_wr_cnt", wr_cnt, w0 + 1);
      check_val("restart_halted", {31'b0, halted}, 1);
      check_val("wr_left_end", exp_wr.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
